commit_ctl: RTL and testbench

- In-order retirement controller sitting directly downstream of the reorder buffer. It consumes the ROB head entry through a valid/ready handshake.
- Per retired instruction it writes the integer register file, clears the matching register-status tag, and hands stores to the store buffer.
- Branch mispredictions and exceptions are turned into a one-cycle pipeline flush with a fetch redirect.
- It keeps a 64-bit retired-instruction counter.

---
 rtl/commit_ctl.sv | 136 +++++++++++++
 tb/tb_commit_ctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctl.sv
// In-order retirement controller: pops the ROB head, writes the register file,
// commits stores and turns mispredicts/exceptions into a one-cycle flush and redirect.
module commit_ctl #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ROB_IDX_W = 2,
  parameter int unsigned EXC_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 comm_valid_i,
  output logic                 comm_ready_o,
  input  logic [ROB_IDX_W-1:0] comm_head_idx_i,
  input  logic [XLEN-1:0]      comm_pc_i,
  input  logic                 comm_rd_upd_i,
  input  logic [4:0]           comm_rd_idx_i,
  input  logic [XLEN-1:0]      comm_res_value_i,
  input  logic                 comm_is_store_i,
  input  logic                 comm_mispred_i,
  input  logic [XLEN-1:0]      comm_target_i,
  input  logic                 comm_except_raised_i,
  input  logic [EXC_W-1:0]     comm_except_code_i,
  input  logic [XLEN-1:0]      mtvec_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 rs_clr_valid_o,
  output logic [ROB_IDX_W-1:0] rs_clr_rob_idx_o,
  output logic                 sb_commit_valid_o,
  input  logic                 sb_commit_ready_i,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic [XLEN-1:0]      mepc_o,
  output logic [EXC_W-1:0]     mcause_o,
  output logic                 exc_valid_o,
  output logic [63:0]          instret_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StExcept} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic [EXC_W-1:0] cause_q, cause_d;
  logic [63:0]      instret_q, instret_d;
  logic             pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      target_q  <= '0;
      mepc_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      mepc_q    <= mepc_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    target_d          = target_q;
    mepc_d            = mepc_q;
    cause_d           = cause_q;
    instret_d         = instret_q;
    pop               = 1'b0;
    comm_ready_o      = 1'b0;
    rf_we_o           = 1'b0;
    rf_waddr_o        = '0;
    rf_wdata_o        = '0;
    rs_clr_valid_o    = 1'b0;
    rs_clr_rob_idx_o  = '0;
    sb_commit_valid_o = 1'b0;
    flush_o           = 1'b0;
    redirect_valid_o  = 1'b0;
    redirect_pc_o     = '0;
    mepc_o            = '0;
    mcause_o          = '0;
    exc_valid_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (comm_valid_i) begin
          if (comm_except_raised_i) begin
            // Exception wins: no architectural side effects from this head.
            comm_ready_o = 1'b1;
            mepc_d       = comm_pc_i;
            cause_d      = comm_except_code_i;
            state_d      = StExcept;
          end else begin
            sb_commit_valid_o = comm_is_store_i;
            pop               = comm_is_store_i ? sb_commit_ready_i : 1'b1;
            comm_ready_o      = pop;
            if (pop) begin
              rf_we_o = comm_rd_upd_i && !comm_is_store_i && (comm_rd_idx_i != 5'd0);
              if (rf_we_o) begin
                rf_waddr_o = comm_rd_idx_i;
                rf_wdata_o = comm_res_value_i;
              end
              rs_clr_valid_o = comm_rd_upd_i;
              if (comm_rd_upd_i) rs_clr_rob_idx_o = comm_head_idx_i;
              instret_d = instret_q + 64'd1;
              if (comm_mispred_i) begin
                target_d = comm_target_i;
                state_d  = StFlush;
              end
            end
          end
        end
      end
      StFlush: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        state_d          = StIdle;
      end
      StExcept: begin
        flush_o          = 1'b1;
        exc_valid_o      = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mtvec_i & ~XLEN'(3);
        mepc_o           = mepc_q;
        mcause_o         = cause_q;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_commit_ctl.sv
// Scoreboard bench for commit_ctl: each driven cycle pushes its expected outputs,
// which are popped and compared against the DUT mid-cycle.
module tb_commit_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        comm_valid, comm_ready;
  logic [1:0]  head_idx;
  logic [63:0] pc;
  logic        rd_upd;
  logic [4:0]  rd_idx;
  logic [63:0] res_value;
  logic        is_store, mispred;
  logic [63:0] target;
  logic        exc_raised;
  logic [3:0]  exc_code;
  logic [63:0] mtvec;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        rs_clr_valid;
  logic [1:0]  rs_clr_idx;
  logic        sb_valid, sb_ready;
  logic        flush, redir_valid;
  logic [63:0] redir_pc, mepc;
  logic [3:0]  mcause;
  logic        exc_valid;
  logic [63:0] instret;

  always #5 clk = ~clk;

  commit_ctl #(.XLEN(64), .ROB_IDX_W(2), .EXC_W(4)) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .comm_valid_i         (comm_valid),
    .comm_ready_o         (comm_ready),
    .comm_head_idx_i      (head_idx),
    .comm_pc_i            (pc),
    .comm_rd_upd_i        (rd_upd),
    .comm_rd_idx_i        (rd_idx),
    .comm_res_value_i     (res_value),
    .comm_is_store_i      (is_store),
    .comm_mispred_i       (mispred),
    .comm_target_i        (target),
    .comm_except_raised_i (exc_raised),
    .comm_except_code_i   (exc_code),
    .mtvec_i              (mtvec),
    .rf_we_o              (rf_we),
    .rf_waddr_o           (rf_waddr),
    .rf_wdata_o           (rf_wdata),
    .rs_clr_valid_o       (rs_clr_valid),
    .rs_clr_rob_idx_o     (rs_clr_idx),
    .sb_commit_valid_o    (sb_valid),
    .sb_commit_ready_i    (sb_ready),
    .flush_o              (flush),
    .redirect_valid_o     (redir_valid),
    .redirect_pc_o        (redir_pc),
    .mepc_o               (mepc),
    .mcause_o             (mcause),
    .exc_valid_o          (exc_valid),
    .instret_o            (instret)
  );

  typedef struct {
    string       name;
    logic        ready;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        rs_clr;
    logic [1:0]  rs_idx;
    logic        sb_v;
    logic        flush;
    logic        redir;
    logic [63:0] redir_pc;
    logic        exc;
    logic [63:0] mepc;
    logic [3:0]  mcause;
    logic [63:0] instret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] ir;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t quiet(input string name, input logic [63:0] cnt);
    exp_t e;
    e.name = name;   e.ready = 1'b0;  e.rf_we = 1'b0;   e.waddr = '0;
    e.wdata = '0;    e.rs_clr = 1'b0; e.rs_idx = '0;    e.sb_v = 1'b0;
    e.flush = 1'b0;  e.redir = 1'b0;  e.redir_pc = '0;  e.exc = 1'b0;
    e.mepc = '0;     e.mcause = '0;   e.instret = cnt;
    return e;
  endfunction

  // Push the expectation, sample 2 time units later, optionally advance to next negedge.
  task automatic step(input exp_t ex, input bit adv);
    exp_t e;
    exp_q.push_back(ex);
    #2;
    e = exp_q.pop_front();
    check({e.name, ".ready"},    64'(comm_ready),   64'(e.ready));
    check({e.name, ".rf_we"},    64'(rf_we),        64'(e.rf_we));
    check({e.name, ".waddr"},    64'(rf_waddr),     64'(e.waddr));
    check({e.name, ".wdata"},    rf_wdata,          e.wdata);
    check({e.name, ".rs_clr"},   64'(rs_clr_valid), 64'(e.rs_clr));
    check({e.name, ".rs_idx"},   64'(rs_clr_idx),   64'(e.rs_idx));
    check({e.name, ".sb_v"},     64'(sb_valid),     64'(e.sb_v));
    check({e.name, ".flush"},    64'(flush),        64'(e.flush));
    check({e.name, ".redir"},    64'(redir_valid),  64'(e.redir));
    check({e.name, ".redir_pc"}, redir_pc,          e.redir_pc);
    check({e.name, ".exc"},      64'(exc_valid),    64'(e.exc));
    check({e.name, ".mepc"},     mepc,              e.mepc);
    check({e.name, ".mcause"},   64'(mcause),       64'(e.mcause));
    check({e.name, ".instret"},  instret,           e.instret);
    if (adv) @(negedge clk);
  endtask

  task automatic head(input logic v, input logic [1:0] idx, input logic [63:0] hpc,
                      input logic upd, input logic [4:0] rd, input logic [63:0] val,
                      input logic st, input logic mp, input logic [63:0] tgt,
                      input logic ex, input logic [3:0] code);
    comm_valid = v;   head_idx = idx; pc = hpc;      rd_upd = upd;
    rd_idx = rd;      res_value = val; is_store = st; mispred = mp;
    target = tgt;     exc_raised = ex; exc_code = code;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [4:0] rd;
    rst_n = 1'b0;
    sb_ready = 1'b0;
    mtvec = 64'h2003;
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ir = 0;
    @(negedge clk);
    step(quiet("reset", 0), 1);
    rst_n = 1'b1;
    step(quiet("idle", 0), 1);

    // Back-to-back ALU heads, rd = 5, 6, 0
    for (int i = 0; i < 3; i++) begin
      rd = (i == 0) ? 5'd5 : (i == 1) ? 5'd6 : 5'd0;
      head(1, 2'(i), 64'h100 + 64'(4 * i), 1, rd, 64'hA0 + 64'(i), 0, 0, 0, 0, 0);
      e = quiet($sformatf("alu%0d", i), ir);
      e.ready = 1; e.rs_clr = 1; e.rs_idx = 2'(i);
      e.rf_we = (rd != 0);
      if (rd != 0) begin e.waddr = rd; e.wdata = 64'hA0 + 64'(i); end
      step(e, 1);
      ir++;
    end
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(quiet("alu_done", ir), 1);

    // Store stalled by the store buffer for 4 cycles
    head(1, 3, 64'h200, 0, 0, 64'h55, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      e = quiet($sformatf("st_stall%0d", i), ir);
      e.sb_v = 1;
      step(e, 1);
    end
    sb_ready = 1'b1;
    e = quiet("st_pop", ir);
    e.sb_v = 1; e.ready = 1;
    step(e, 1);
    ir++;
    sb_ready = 1'b0;
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(quiet("st_done", ir), 1);

    // Mispredict with link write; next head waits out the flush cycle
    head(1, 1, 64'h400, 1, 1, 64'h404, 0, 1, 64'h8000_0040, 0, 0);
    e = quiet("mp_pop", ir);
    e.ready = 1; e.rf_we = 1; e.waddr = 1; e.wdata = 64'h404; e.rs_clr = 1; e.rs_idx = 1;
    step(e, 1);
    ir++;
    head(1, 2, 64'h8000_0040, 1, 7, 64'h77, 0, 0, 0, 0, 0);
    e = quiet("mp_flush", ir);
    e.flush = 1; e.redir = 1; e.redir_pc = 64'h8000_0040;
    step(e, 1);
    e = quiet("mp_next", ir);
    e.ready = 1; e.rf_we = 1; e.waddr = 7; e.wdata = 64'h77; e.rs_clr = 1; e.rs_idx = 2;
    step(e, 1);
    ir++;

    // Exception: no rf write, then trap redirect to aligned mtvec
    head(1, 0, 64'h1000, 1, 3, 64'h33, 0, 0, 0, 1, 2);
    e = quiet("exc_pop", ir);
    e.ready = 1;
    step(e, 1);
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = quiet("exc_take", ir);
    e.flush = 1; e.redir = 1; e.redir_pc = 64'h2000; e.exc = 1; e.mepc = 64'h1000; e.mcause = 2;
    step(e, 1);
    step(quiet("exc_done", ir), 1);

    // Exception + store + mispredict on one head: exception path only
    head(1, 1, 64'h3000, 1, 9, 64'h99, 1, 1, 64'h9999, 1, 5);
    e = quiet("combo_pop", ir);
    e.ready = 1;
    step(e, 1);
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = quiet("combo_take", ir);
    e.flush = 1; e.redir = 1; e.redir_pc = 64'h2000; e.exc = 1; e.mepc = 64'h3000; e.mcause = 5;
    step(e, 1);
    step(quiet("combo_done", ir), 1);

    // Reset asserted in the middle of a flush cycle
    head(1, 2, 64'h500, 1, 2, 64'h22, 0, 1, 64'h5550, 0, 0);
    e = quiet("rst_mp_pop", ir);
    e.ready = 1; e.rf_we = 1; e.waddr = 2; e.wdata = 64'h22; e.rs_clr = 1; e.rs_idx = 2;
    step(e, 1);
    ir++;
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = quiet("rst_pre_flush", ir);
    e.flush = 1; e.redir = 1; e.redir_pc = 64'h5550;
    step(e, 0);
    rst_n = 1'b0;
    ir = 0;
    #1;
    step(quiet("rst_in_flush", ir), 1);
    rst_n = 1'b1;
    head(1, 3, 64'h600, 1, 4, 64'h44, 0, 0, 0, 0, 0);
    e = quiet("post_rst", ir);
    e.ready = 1; e.rf_we = 1; e.waddr = 4; e.wdata = 64'h44; e.rs_clr = 1; e.rs_idx = 3;
    step(e, 1);
    ir++;
    head(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(quiet("post_rst_idle", ir), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
